// File: rtl/fft_8_input_feeder_pkg.sv
// Shared types for the 8-point FFT input feeder.
package fft_8_input_feeder_pkg;

  localparam int unsigned DataW = 16;

  // One complex sample; real and imaginary parts are two's complement.
  typedef struct packed {
    logic signed [DataW-1:0] r;
    logic signed [DataW-1:0] i;
  } complex_product_t;

  // Read-side FSM: waiting for a full bank, or streaming pairs out of one.
  typedef enum logic [0:0] {
    StIdle,
    StDrain
  } rd_state_e;

endpackage

// File: rtl/fft_8_input_feeder.sv
// Ping-pong input buffer for an 8-point radix-2 FFT. Collects serial samples into one bank
// while the other bank is streamed out as (x[k], x[k+N/2]) pairs.
module fft_8_input_feeder
  import fft_8_input_feeder_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  complex_product_t in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic             out_ready,
  output complex_product_t data_0,
  output complex_product_t data_1,
  output logic             out_valid,
  output logic             out_sof
);

  localparam int unsigned Half    = N / 2;
  localparam int unsigned LogN    = $clog2(N);
  localparam int unsigned LogHalf = $clog2(Half);

  localparam logic [LogN-1:0]    LastWr   = LogN'(N - 1);
  localparam logic [LogHalf-1:0] LastBeat = LogHalf'(Half - 1);

  // Sample storage; contents are only meaningful while the matching full bit is set.
  complex_product_t bank_q [2][N];

  logic [LogN-1:0]    wr_cnt_q, wr_cnt_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [1:0]         full_q, full_d;
  logic [LogHalf-1:0] k_q, k_d;
  rd_state_e          state_q, state_d;
  complex_product_t   data_0_q, data_0_d;
  complex_product_t   data_1_q, data_1_d;
  logic               out_valid_q, out_valid_d;
  logic               out_sof_q, out_sof_d;

  logic               wr_en;
  logic               wr_wrap;
  logic               beat_acc;
  logic               load;
  logic               ld_bank;
  logic [LogHalf-1:0] ld_k;
  logic [LogN-1:0]    rd_addr_lo;
  logic [LogN-1:0]    rd_addr_hi;

  // Reset forces ready high so the producer sees an empty feeder from the first reset cycle.
  assign in_ready = reset | ~full_q[wr_bank_q];
  assign wr_en    = in_valid & in_ready & ~flush & ~reset;
  assign wr_wrap  = wr_en & (wr_cnt_q == LastWr);
  assign beat_acc = out_valid_q & out_ready;

  // Write side: fill position and bank select; flush discards the partial frame.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (flush) begin
      wr_cnt_d = '0;
    end else if (wr_en) begin
      wr_cnt_d = wr_cnt_q + LogN'(1);
      if (wr_wrap) begin
        wr_bank_d = ~wr_bank_q;
      end
    end
  end

  // Read FSM: decides which pair (if any) is loaded into the output registers next.
  always_comb begin
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    k_d         = k_q;
    full_d      = full_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    load        = 1'b0;
    ld_bank     = rd_bank_q;
    ld_k        = '0;

    // Filling and draining always target different banks, so both updates can coexist.
    if (wr_wrap) begin
      full_d[wr_bank_q] = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q]) begin
          load    = 1'b1;
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (beat_acc) begin
          if (k_q != LastBeat) begin
            load = 1'b1;
            ld_k = k_q + LogHalf'(1);
          end else begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            // Next frame already waiting: chain straight into it without an idle cycle.
            if (full_q[~rd_bank_q]) begin
              load    = 1'b1;
              ld_bank = ~rd_bank_q;
            end else begin
              state_d     = StIdle;
              out_valid_d = 1'b0;
              out_sof_d   = 1'b0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      k_d         = ld_k;
      out_valid_d = 1'b1;
      out_sof_d   = (ld_k == '0);
    end
  end

  assign rd_addr_lo = LogN'(ld_k);
  assign rd_addr_hi = rd_addr_lo + LogN'(Half);
  assign data_0_d   = load ? bank_q[ld_bank][rd_addr_lo] : data_0_q;
  assign data_1_d   = load ? bank_q[ld_bank][rd_addr_hi] : data_1_q;

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      k_q         <= '0;
      state_q     <= StIdle;
      data_0_q    <= '0;
      data_1_q    <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      k_q         <= k_d;
      state_q     <= state_d;
      data_0_q    <= data_0_d;
      data_1_q    <= data_1_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
    end
  end

  // Sample storage write; no reset needed since full bits gate every read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_q[wr_bank_q][wr_cnt_q] <= in_data;
    end
  end

  assign data_0    = data_0_q;
  assign data_1    = data_1_q;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;

endmodule

// File: tb/tb_fft_8_input_feeder.sv
// Bench for fft_8_input_feeder: a frame model feeds a pair scoreboard, plus a per-cycle
// vector table for the ramp frame and hand sequences for flow-control corner cases.
module tb_fft_8_input_feeder;
  import fft_8_input_feeder_pkg::*;

  typedef struct packed {
    complex_product_t d0;
    complex_product_t d1;
    logic             sof;
  } pair_t;

  typedef struct {
    logic        vld;
    logic [15:0] r;
    logic        ordy;
    logic        e_irdy;
    logic        e_ovld;
    logic        e_sof;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic             out_ready;
  logic             out_valid;
  logic             out_sof;
  complex_product_t in_data;
  complex_product_t data_0;
  complex_product_t data_1;

  int               checks = 0;
  int               errors = 0;
  int               beats  = 0;
  int               b0;
  int               found;
  pair_t            q[$];
  complex_product_t frame[8];
  int               mdl_cnt = 0;
  vec_t             vecs[14];

  always #5 clk = ~clk;

  fft_8_input_feeder #(.N(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .flush    (flush),
    .out_ready(out_ready),
    .data_0   (data_0),
    .data_1   (data_1),
    .out_valid(out_valid),
    .out_sof  (out_sof)
  );

  function automatic complex_product_t mk(input int r);
    complex_product_t s;
    s.r = DataW'(r);
    s.i = DataW'(-3 * r - 1);
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Observe this cycle's handshakes (inputs already driven, edge not yet taken).
  task automatic sb_step();
    pair_t e;
    if (reset) begin
      q.delete();
      mdl_cnt = 0;
      return;
    end
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_pair: got d0.r=%0d d1.r=%0d expected no pair",
                 data_0.r, data_1.r);
      end else begin
        e = q[0];
        check("sb_data_0", data_0, e.d0);
        check("sb_data_1", data_1, e.d1);
        check("sb_sof", {31'd0, out_sof}, {31'd0, e.sof});
        if (out_ready) begin
          void'(q.pop_front());
          beats++;
        end
      end
    end
    if (flush) begin
      mdl_cnt = 0;
    end else if (in_valid && in_ready) begin
      frame[mdl_cnt] = in_data;
      mdl_cnt++;
      if (mdl_cnt == 8) begin
        for (int k = 0; k < 4; k++) begin
          q.push_back('{d0: frame[k], d1: frame[k+4], sof: (k == 0)});
        end
        mdl_cnt = 0;
      end
    end
  endtask

  task automatic advance();
    sb_step();
    @(negedge clk);
  endtask

  task automatic cycle();
    #1;
    advance();
  endtask

  task automatic send(input int r);
    in_valid = 1'b1;
    in_data  = mk(r);
    cycle();
  endtask

  task automatic drain(input string name);
    in_valid = 1'b0;
    for (int c = 0; c < 40 && q.size() != 0; c++) cycle();
    check(name, q.size(), 0);
    repeat (3) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state, observed while reset is still held.
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_sof", {31'd0, out_sof}, 0);
    check("rst_data_0", data_0, 0);
    check("rst_data_1", data_1, 0);
    advance();
    reset = 1'b0;

    // Ramp frame: sample t on cycle t, pairs visible cycles 9..12.
    for (int t = 0; t < 14; t++) begin
      vecs[t].vld    = (t < 8);
      vecs[t].r      = 16'(t);
      vecs[t].ordy   = 1'b1;
      vecs[t].e_irdy = 1'b1;
      vecs[t].e_ovld = (t >= 9 && t <= 12);
      vecs[t].e_sof  = (t == 9);
      vecs[t].e0     = 16'(t - 9);
      vecs[t].e1     = 16'(t - 5);
    end
    for (int t = 0; t < 14; t++) begin
      in_valid  = vecs[t].vld;
      in_data   = mk(int'(vecs[t].r));
      out_ready = vecs[t].ordy;
      #1;
      check("ramp_in_ready", {31'd0, in_ready}, {31'd0, vecs[t].e_irdy});
      check("ramp_out_valid", {31'd0, out_valid}, {31'd0, vecs[t].e_ovld});
      check("ramp_out_sof", {31'd0, out_sof}, {31'd0, vecs[t].e_sof});
      if (vecs[t].e_ovld) begin
        check("ramp_data_0_r", {16'd0, data_0.r}, {16'd0, vecs[t].e0});
        check("ramp_data_1_r", {16'd0, data_1.r}, {16'd0, vecs[t].e1});
      end
      advance();
    end
    check("ramp_drained", q.size(), 0);

    // Back-to-back frames.
    b0 = beats;
    for (int s = 0; s < 16; s++) begin
      in_valid = 1'b1;
      in_data  = mk(s);
      #1;
      check("b2b_in_ready", {31'd0, in_ready}, 1);
      advance();
    end
    drain("b2b_drained");
    check("b2b_beats", beats - b0, 8);

    // Backpressure: both banks fill, then drain without a gap.
    out_ready = 1'b0;
    for (int s = 0; s < 17; s++) begin
      in_valid = 1'b1;
      in_data  = mk(s);
      #1;
      check("bp_in_ready", {31'd0, in_ready}, (s < 16) ? 1 : 0);
      advance();
    end
    in_valid = 1'b0;
    repeat (3) begin
      #1;
      check("bp_hold_valid", {31'd0, out_valid}, 1);
      check("bp_hold_d0", data_0, mk(0));
      check("bp_hold_d1", data_1, mk(4));
      check("bp_in_ready_low", {31'd0, in_ready}, 0);
      advance();
    end
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      #1;
      check("bp_drain_valid", {31'd0, out_valid}, 1);
      advance();
    end
    #1;
    check("bp_in_ready_back", {31'd0, in_ready}, 1);
    check("bp_drained", q.size(), 0);
    advance();

    // Flush: partial frame dropped, and flush beats a same-cycle sample.
    b0 = beats;
    for (int s = 0; s < 5; s++) send(50 + s);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = mk(99);
    cycle();
    flush = 1'b0;
    for (int s = 0; s < 8; s++) send(100 + s);
    drain("flush_drained");
    check("flush_beats", beats - b0, 4);

    // Reset mid-drain, right after beat (1,5).
    for (int s = 0; s < 8; s++) send(s);
    in_valid = 1'b0;
    found    = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      #1;
      if (out_valid && data_0 == mk(1)) found = 1;
      advance();
    end
    check("rst_mid_beat1_seen", found, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    check("rst_mid_out_valid", {31'd0, out_valid}, 0);
    check("rst_mid_data_0", data_0, 0);
    check("rst_mid_in_ready", {31'd0, in_ready}, 1);
    advance();
    b0 = beats;
    for (int s = 0; s < 8; s++) send(20 + s);
    drain("rst_mid_drained");
    check("rst_mid_beats", beats - b0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
